// File: rtl/repairable_mem_pkg.sv
// Shared types for repairable_mem: repair FSM state encoding, repair result codes
// and a helper sizing the spare-entry index.
package repairable_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StAck,
        StWait
    } rep_state_e;

    localparam logic [1:0] REP_OK    = 2'b00;
    localparam logic [1:0] REP_DUP   = 2'b01;
    localparam logic [1:0] REP_FULL  = 2'b10;
    localparam logic [1:0] REP_RANGE = 2'b11;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/repair_cam.sv
// Remap table: SPARE_COUNT valid/address entries, access hit lookup, repair-address
// duplicate query and lowest-free-entry allocation.
module repair_cam
    import repairable_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned SPARE_COUNT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [ADDR_WIDTH-1:0]                  acc_addr,
    output logic                                   acc_hit,
    output logic [idx_width(SPARE_COUNT)-1:0]      acc_idx,
    input  logic [ADDR_WIDTH-1:0]                  qry_addr,
    output logic                                   qry_hit,
    input  logic                                   alloc_en,
    output logic [$clog2(SPARE_COUNT+1)-1:0]       count
);

    localparam int unsigned IdxWidth = idx_width(SPARE_COUNT);
    localparam int unsigned CntWidth = $clog2(SPARE_COUNT + 1);

    logic [SPARE_COUNT-1:0] valid_q;
    logic [ADDR_WIDTH-1:0]  addr_q [SPARE_COUNT];
    logic [CntWidth-1:0]    count_q;
    logic [IdxWidth-1:0]    free_idx;

    always_comb begin
        acc_hit  = 1'b0;
        acc_idx  = '0;
        qry_hit  = 1'b0;
        free_idx = '0;
        for (int i = 0; i < int'(SPARE_COUNT); i++) begin
            if (valid_q[i] && addr_q[i] == acc_addr) begin
                acc_hit = 1'b1;
                acc_idx = IdxWidth'(i);
            end
            if (valid_q[i] && addr_q[i] == qry_addr) begin
                qry_hit = 1'b1;
            end
        end
        // Descending scan so the lowest free entry wins.
        for (int i = int'(SPARE_COUNT) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IdxWidth'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (alloc_en && count_q != CntWidth'(SPARE_COUNT)) begin
            valid_q[free_idx] <= 1'b1;
            count_q           <= count_q + 1'b1;
        end
    end

    // Addresses are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc_en && count_q != CntWidth'(SPARE_COUNT)) begin
            addr_q[free_idx] <= qry_addr;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/repairable_mem.sv
// Word memory with byte-enable writes, spare-word remapping and a repair handshake.
// Optional stuck-at-1 read fault injection when MEM_FAULT_INJECT_EN is defined.
module repairable_mem
    import repairable_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_SIZE    = 256,
    parameter int unsigned SPARE_COUNT = 4,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
`ifdef MEM_FAULT_INJECT_EN
    input  logic                               fi_en,
    input  logic [ADDR_WIDTH-1:0]              fi_addr,
    input  logic [$clog2(DATA_WIDTH)-1:0]      fi_bit,
`endif
    input  logic                               mem_en,
    input  logic                               mem_we,
    input  logic [DATA_WIDTH/8-1:0]            mem_be,
    input  logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               mem_rvalid,
    input  logic                               rep_req,
    input  logic [ADDR_WIDTH-1:0]              rep_addr,
    output logic                               rep_ack,
    output logic [1:0]                         rep_status,
    output logic [$clog2(SPARE_COUNT+1)-1:0]   rep_count,
    output logic                               rep_full
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = idx_width(SPARE_COUNT);
    localparam int unsigned CntWidth = $clog2(SPARE_COUNT + 1);
    localparam logic [ADDR_WIDTH:0] MemSize = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [DATA_WIDTH-1:0] main_mem  [MEM_SIZE];
    logic [DATA_WIDTH-1:0] spare_mem [SPARE_COUNT];

    logic                  acc_hit;
    logic [IdxWidth-1:0]   acc_idx;
    logic                  qry_hit;
    logic                  alloc_en;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    rep_state_e            state_q, state_d;
    logic [1:0]            status_q, status_d;
    logic [ADDR_WIDTH-1:0] rep_addr_q;

    repair_cam #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SPARE_COUNT (SPARE_COUNT)
    ) u_cam (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc_addr (mem_addr),
        .acc_hit  (acc_hit),
        .acc_idx  (acc_idx),
        .qry_addr (rep_addr_q),
        .qry_hit  (qry_hit),
        .alloc_en (alloc_en),
        .count    (rep_count)
    );

    assign in_range = {1'b0, mem_addr} < MemSize;
    assign rep_full = rep_count == CntWidth'(SPARE_COUNT);

    always_ff @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (mem_be[b]) begin
                    if (acc_hit) begin
                        spare_mem[acc_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                    end else if (in_range) begin
                        main_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (acc_hit) begin
            rd_word = spare_mem[acc_idx];
        end else if (in_range) begin
            rd_word = main_mem[mem_addr];
`ifdef MEM_FAULT_INJECT_EN
            if (fi_en && fi_addr == mem_addr) begin
                rd_word[fi_bit] = 1'b1;
            end
`endif
        end
    end

    // First read stage; at RD_LATENCY=1 it drives the outputs directly.
    logic                  p1_valid_q;
    logic [DATA_WIDTH-1:0] p1_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
        end else begin
            p1_valid_q <= mem_en && !mem_we;
            if (mem_en && !mem_we) begin
                p1_data_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  p2_valid_q;
        logic [DATA_WIDTH-1:0] p2_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p2_valid_q <= 1'b0;
                p2_data_q  <= '0;
            end else begin
                p2_valid_q <= p1_valid_q;
                if (p1_valid_q) begin
                    p2_data_q <= p1_data_q;
                end
            end
        end

        assign mem_rvalid = p2_valid_q;
        assign mem_rdata  = p2_data_q;
    end else begin : g_lat1
        assign mem_rvalid = p1_valid_q;
        assign mem_rdata  = p1_data_q;
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        alloc_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rep_req) state_d = StLookup;
            end
            StLookup: begin
                state_d = StAck;
                if ({1'b0, rep_addr_q} >= MemSize) status_d = REP_RANGE;
                else if (qry_hit)                  status_d = REP_DUP;
                else if (rep_full)                 status_d = REP_FULL;
                else                               status_d = REP_OK;
            end
            // Entry is written on leaving ACK so accesses during ACK see the old map.
            StAck: begin
                state_d  = StWait;
                alloc_en = status_q == REP_OK;
            end
            StWait: begin
                if (!rep_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            status_q   <= REP_OK;
            rep_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == StIdle && rep_req) begin
                rep_addr_q <= rep_addr;
            end
        end
    end

    assign rep_ack    = state_q == StAck;
    assign rep_status = status_q;

endmodule
